// File: rtl/rtc_bus_sequencer_if.sv
// Processor/pad-side signal bundle for the RTC multiplexed-bus sequencer.
// Handshake: a rising edge of req_wr or req_rd seen while idle starts one
// transaction; busy stays high from the first address phase through the done
// cycle, done pulses for exactly one cycle, and edges seen while busy are dropped.
interface rtc_bus_sequencer_if;
  logic       req_wr;
  logic       req_rd;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       cs_n;
  logic       a_d_n;
  logic       rd_n;
  logic       wr_n;
  logic [7:0] rd_data;
  logic       busy;
  logic       done;
  logic [3:0] dbg_state;

  modport master (
    output req_wr, req_rd, addr, wdata, ad_in,
    input  ad_out, ad_oe, cs_n, a_d_n, rd_n, wr_n, rd_data, busy, done, dbg_state
  );

  modport slave (
    input  req_wr, req_rd, addr, wdata, ad_in,
    output ad_out, ad_oe, cs_n, a_d_n, rd_n, wr_n, rd_data, busy, done, dbg_state
  );
endinterface

// File: rtl/rtc_bus_sequencer.sv
// Runs one address-phase + data-phase RTC bus transaction per request edge,
// with T_PH clock cycles per phase and fully registered pad/status outputs.
module rtc_bus_sequencer #(
  parameter int unsigned T_PH = 4
) (
  input logic               clk,
  input logic               rst,
  rtc_bus_sequencer_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_A_SETUP, S_A_STROBE, S_A_HOLD, S_GAP,
    S_D_SETUP, S_D_STROBE, S_D_HOLD, S_DONE
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(T_PH - 1);

  state_t     state, state_d;
  logic [7:0] cnt;
  logic       req_wr_q, req_rd_q;
  logic       is_rd_q, is_rd_nx;
  logic [7:0] addr_q, addr_nx;
  logic [7:0] wdata_q, wdata_nx;
  logic       start_wr, start_rd, start, phase_end;

  logic       cs_n_r, a_d_n_r, rd_n_r, wr_n_r, ad_oe_r, busy_r, done_r;
  logic [7:0] ad_out_r, rd_data_r;
  logic       cs_n_d, a_d_n_d, rd_n_d, wr_n_d, ad_oe_d, busy_d, done_d;
  logic [7:0] ad_out_d;

  assign start_wr  = bus.req_wr & ~req_wr_q;
  assign start_rd  = bus.req_rd & ~req_rd_q;
  assign start     = (state == S_IDLE) && (start_wr || start_rd);
  assign phase_end = (cnt == LAST_CNT);

  // Values the transaction will use from the next edge on; lets the outputs of
  // the first address cycle be registered straight from the request inputs.
  assign addr_nx  = start ? bus.addr  : addr_q;
  assign wdata_nx = start ? bus.wdata : wdata_q;
  assign is_rd_nx = start ? ~start_wr : is_rd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= 8'd0;
      req_wr_q <= 1'b0;
      req_rd_q <= 1'b0;
      is_rd_q  <= 1'b0;
      addr_q   <= 8'd0;
      wdata_q  <= 8'd0;
    end else begin
      state    <= state_d;
      req_wr_q <= bus.req_wr;
      req_rd_q <= bus.req_rd;
      is_rd_q  <= is_rd_nx;
      addr_q   <= addr_nx;
      wdata_q  <= wdata_nx;
      if (state_d != state || state == S_IDLE) cnt <= 8'd0;
      else                                     cnt <= cnt + 8'd1;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:     if (start)     state_d = S_A_SETUP;
      S_A_SETUP:  if (phase_end) state_d = S_A_STROBE;
      S_A_STROBE: if (phase_end) state_d = S_A_HOLD;
      S_A_HOLD:   if (phase_end) state_d = S_GAP;
      S_GAP:      if (phase_end) state_d = S_D_SETUP;
      S_D_SETUP:  if (phase_end) state_d = S_D_STROBE;
      S_D_STROBE: if (phase_end) state_d = S_D_HOLD;
      S_D_HOLD:   if (phase_end) state_d = S_DONE;
      S_DONE:                    state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
  end

  // Output values are decoded from the state being entered, then registered.
  always_comb begin
    cs_n_d   = 1'b1;
    a_d_n_d  = 1'b1;
    rd_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    ad_oe_d  = 1'b0;
    ad_out_d = ad_out_r;
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    case (state_d)
      S_A_SETUP, S_A_STROBE, S_A_HOLD: begin
        cs_n_d   = 1'b0;
        a_d_n_d  = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_nx;
        wr_n_d   = (state_d != S_A_STROBE);
      end
      S_D_SETUP, S_D_STROBE, S_D_HOLD: begin
        cs_n_d = 1'b0;
        if (!is_rd_nx) begin
          ad_oe_d  = 1'b1;
          ad_out_d = wdata_nx;
        end
        if (state_d == S_D_STROBE) begin
          rd_n_d = ~is_rd_nx;
          wr_n_d = is_rd_nx;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_n_r    <= 1'b1;
      a_d_n_r   <= 1'b1;
      rd_n_r    <= 1'b1;
      wr_n_r    <= 1'b1;
      ad_oe_r   <= 1'b0;
      ad_out_r  <= 8'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      rd_data_r <= 8'd0;
    end else begin
      cs_n_r   <= cs_n_d;
      a_d_n_r  <= a_d_n_d;
      rd_n_r   <= rd_n_d;
      wr_n_r   <= wr_n_d;
      ad_oe_r  <= ad_oe_d;
      ad_out_r <= ad_out_d;
      busy_r   <= busy_d;
      done_r   <= done_d;
      // Sample the pad on the edge that closes the read strobe.
      if (state == S_D_STROBE && phase_end && is_rd_q) rd_data_r <= bus.ad_in;
    end
  end

  assign bus.cs_n      = cs_n_r;
  assign bus.a_d_n     = a_d_n_r;
  assign bus.rd_n      = rd_n_r;
  assign bus.wr_n      = wr_n_r;
  assign bus.ad_oe     = ad_oe_r;
  assign bus.ad_out    = ad_out_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.rd_data   = rd_data_r;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Bench for rtc_bus_sequencer: table of transactions on a T_PH=4 instance,
// hand sequences for held/abort cases, and a T_PH=1 instance.
module tb_rtc_bus_sequencer;
  localparam int T4 = 4;
  localparam int T1 = 1;

  typedef struct packed {
    logic       cs_n;
    logic       a_d_n;
    logic       rd_n;
    logic       wr_n;
    logic       ad_oe;
    logic       busy;
    logic       done;
    logic [7:0] ad_out;
    logic [7:0] rd_data;
  } obs_t;

  typedef struct {
    logic       is_rd;
    logic       both;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] ad_val;
    logic [7:0] exp_rd;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rtc_bus_sequencer_if bus4();
  rtc_bus_sequencer_if bus1();

  rtc_bus_sequencer #(.T_PH(T4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  rtc_bus_sequencer #(.T_PH(T1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  obs_t obs4, obs1;
  assign obs4 = {bus4.cs_n, bus4.a_d_n, bus4.rd_n, bus4.wr_n, bus4.ad_oe,
                 bus4.busy, bus4.done, bus4.ad_out, bus4.rd_data};
  assign obs1 = {bus1.cs_n, bus1.a_d_n, bus1.rd_n, bus1.wr_n, bus1.ad_oe,
                 bus1.busy, bus1.done, bus1.ad_out, bus1.rd_data};

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [7:0] exp_q4[$];
  logic [7:0] exp_q1[$];
  logic [7:0] last_rd[2];
  logic [7:0] sb_e4, sb_e1;
  vec_t vecs[7];

  // ---------------- check helpers ----------------
  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %02h expected %02h", name, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic cmp_obs(input string tag, input obs_t a, input obs_t e);
    chk1({tag, " cs_n"},  a.cs_n,  e.cs_n);
    chk1({tag, " a_d_n"}, a.a_d_n, e.a_d_n);
    chk1({tag, " rd_n"},  a.rd_n,  e.rd_n);
    chk1({tag, " wr_n"},  a.wr_n,  e.wr_n);
    chk1({tag, " ad_oe"}, a.ad_oe, e.ad_oe);
    chk1({tag, " busy"},  a.busy,  e.busy);
    chk1({tag, " done"},  a.done,  e.done);
    chk8({tag, " rd_data"}, a.rd_data, e.rd_data);
    if (e.ad_oe) chk8({tag, " ad_out"}, a.ad_out, e.ad_out);
  endtask

  function automatic obs_t idle_obs(input logic [7:0] rd);
    obs_t e;
    e = '0;
    e.cs_n = 1'b1; e.a_d_n = 1'b1; e.rd_n = 1'b1; e.wr_n = 1'b1;
    e.rd_data = rd;
    return e;
  endfunction

  // Expected pad/status outputs in cycle k after address-setup entry.
  function automatic obs_t expect_cycle(input int t, input int k, input logic is_rd,
                                        input logic [7:0] a, input logic [7:0] d,
                                        input logic [7:0] old_rd, input logic [7:0] new_rd);
    obs_t e;
    int p;
    p = k / t;
    e = idle_obs((k >= 6 * t) ? new_rd : old_rd);
    e.busy = 1'b1;
    case (p)
      0, 1, 2: begin
        e.cs_n = 1'b0; e.a_d_n = 1'b0; e.ad_oe = 1'b1; e.ad_out = a;
        if (p == 1) e.wr_n = 1'b0;
      end
      4, 5, 6: begin
        e.cs_n = 1'b0;
        if (!is_rd) begin e.ad_oe = 1'b1; e.ad_out = d; end
        if (p == 5) begin
          if (is_rd) e.rd_n = 1'b0;
          else       e.wr_n = 1'b0;
        end
      end
      7: e.done = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_req(input int sel, input logic wr, input logic rd);
    if (sel == 1) begin bus1.req_wr = wr; bus1.req_rd = rd; end
    else          begin bus4.req_wr = wr; bus4.req_rd = rd; end
  endtask

  task automatic set_ad(input int sel, input logic [7:0] a, input logic [7:0] d);
    if (sel == 1) begin bus1.addr = a; bus1.wdata = d; end
    else          begin bus4.addr = a; bus4.wdata = d; end
  endtask

  task automatic set_in(input int sel, input logic [7:0] v);
    if (sel == 1) bus1.ad_in = v;
    else          bus4.ad_in = v;
  endtask

  // Starts a transaction at a negedge, checks every cycle through done and the
  // idle cycle after it. addr/wdata are scrambled once the request is taken.
  task automatic run_txn(input int sel, input int t, input vec_t v, input string tag,
                         input logic hold, input int extra_wr_k);
    logic [7:0] old_rd;
    logic       eff_rd;
    old_rd = last_rd[sel];
    eff_rd = v.is_rd & ~v.both;
    set_ad(sel, v.addr, v.wdata);
    set_req(sel, ~v.is_rd | v.both, v.is_rd);
    if (sel == 1) exp_q1.push_back(v.exp_rd);
    else          exp_q4.push_back(v.exp_rd);
    for (int k = 0; k <= 7 * t; k++) begin
      @(negedge clk);
      cyc = k;
      cmp_obs(tag, (sel == 1) ? obs1 : obs4,
              expect_cycle(t, k, eff_rd, v.addr, v.wdata, old_rd, v.exp_rd));
      if (k == 0) begin
        set_ad(sel, v.addr ^ 8'h5E, v.wdata ^ 8'hA3);
        if (!hold) set_req(sel, 1'b0, 1'b0);
      end
      if (k == extra_wr_k) set_req(sel, 1'b1, v.is_rd);
      set_in(sel, (k >= 5 * t && k < 6 * t) ? v.ad_val : ~v.ad_val);
    end
    @(negedge clk);
    cyc = 7 * t + 1;
    cmp_obs({tag, " after"}, (sel == 1) ? obs1 : obs4, idle_obs(v.exp_rd));
    last_rd[sel] = v.exp_rd;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && bus4.done) begin
      if (exp_q4.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL sb4 done: got unexpected done, expected no completion");
      end else begin
        sb_e4 = exp_q4.pop_front();
        chk8("sb4 rd_data", bus4.rd_data, sb_e4);
      end
    end
    if (!rst && bus1.done) begin
      if (exp_q1.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL sb1 done: got unexpected done, expected no completion");
      end else begin
        sb_e1 = exp_q1.pop_front();
        chk8("sb1 rd_data", bus1.rd_data, sb_e1);
      end
    end
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected test end");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- test sequence ----------------
  initial begin
    vec_t v;
    //             is_rd both  addr   wdata  ad_val exp_rd
    vecs[0] = '{1'b0, 1'b0, 8'h21, 8'h35, 8'h00, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 8'h22, 8'h00, 8'h59, 8'h59};
    vecs[2] = '{1'b1, 1'b1, 8'h30, 8'hA5, 8'h11, 8'h59};
    vecs[3] = '{1'b0, 1'b0, 8'h7F, 8'h0F, 8'h66, 8'h59};
    vecs[4] = '{1'b1, 1'b0, 8'h00, 8'hC3, 8'hFF, 8'hFF};
    vecs[5] = '{1'b1, 1'b0, 8'hFF, 8'h3C, 8'h00, 8'h00};
    vecs[6] = '{1'b0, 1'b0, 8'hFF, 8'hFF, 8'hAA, 8'h00};

    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    set_req(0, 1'b0, 1'b0); set_ad(0, 8'h00, 8'h00); set_in(0, 8'h00);
    set_req(1, 1'b0, 1'b0); set_ad(1, 8'h00, 8'h00); set_in(1, 8'h00);

    repeat (3) @(negedge clk);
    cyc = 0;
    cmp_obs("reset4", obs4, idle_obs(8'h00));
    chk8("reset4 ad_out", bus4.ad_out, 8'h00);
    cmp_obs("reset1", obs1, idle_obs(8'h00));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_txn(0, T4, vecs[i], $sformatf("vec%0d", i), 1'b0, -1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Read request held high with a write edge arriving mid-transaction.
    v = '{1'b1, 1'b0, 8'h55, 8'h00, 8'h9C, 8'h9C};
    run_txn(0, T4, v, "held", 1'b1, 10);
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      chk1("held idle busy", bus4.busy, 1'b0);
    end
    set_req(0, 1'b0, 1'b0);
    @(negedge clk);

    // Reset while the write data strobe is active.
    set_ad(0, 8'h40, 8'h66);
    set_req(0, 1'b1, 1'b0);
    for (int k = 0; k <= 5 * T4 + 1; k++) begin
      @(negedge clk);
      cyc = k;
      if (k == 0) set_req(0, 1'b0, 1'b0);
    end
    chk1("abort in d_strobe wr_n", bus4.wr_n, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    cmp_obs("abort", obs4, idle_obs(8'h00));
    rst = 1'b0;
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      chk1("abort idle busy", bus4.busy, 1'b0);
    end

    v = '{1'b1, 1'b0, 8'h12, 8'h00, 8'h3D, 8'h3D};
    run_txn(0, T4, v, "recover", 1'b0, -1);

    // Single-cycle phases.
    v = '{1'b0, 1'b0, 8'h44, 8'h88, 8'h00, 8'h00};
    run_txn(1, T1, v, "t1 wr", 1'b0, -1);
    @(negedge clk);
    v = '{1'b1, 1'b0, 8'h45, 8'h00, 8'hC3, 8'hC3};
    run_txn(1, T1, v, "t1 rd", 1'b0, -1);
    @(negedge clk);
    v = '{1'b1, 1'b0, 8'h46, 8'h00, 8'h5A, 8'h5A};
    run_txn(1, T1, v, "t1 rd2", 1'b0, -1);

    repeat (3) @(negedge clk);
    chk8("sb4 pending", 8'(exp_q4.size()), 8'd0);
    chk8("sb1 pending", 8'(exp_q1.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
